// File: rtl/stack_pkg.sv
// Shared defaults and operation decode for the LIFO stack.
// decode_op folds the push/pop/peek strobes and the flags into one operation code.
package stack_pkg;

   localparam int DEF_DATA_WIDTH  = 4;
   localparam int DEF_STACK_DEPTH = 16;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] PUSH    = 3'd1;
   localparam logic [2:0] POP     = 3'd2;
   localparam logic [2:0] PEEK    = 3'd3;
   localparam logic [2:0] REPLACE = 3'd4;
   localparam logic [2:0] BYPASS  = 3'd5;

   // Pop outranks peek; an accompanying push turns a pop into a replace or a bypass.
   function automatic logic [2:0] decode_op(input logic push_i, input logic pop_i,
                                            input logic peek_i, input logic empty_i,
                                            input logic full_i);
      logic [2:0] op;
      op = IDLE;
      if (pop_i && push_i)   op = empty_i ? BYPASS : REPLACE;
      else if (pop_i)        op = empty_i ? IDLE : POP;
      else if (push_i)       op = full_i ? IDLE : PUSH;
      else if (peek_i)       op = empty_i ? IDLE : PEEK;
      return op;
   endfunction

endpackage

// File: rtl/stack_ram.sv
// Stack storage: synchronous write, asynchronous read.
// Contents are not reset; every location is written by a push before it can be read.
module stack_ram #(
   parameter int DATA_WIDTH  = 4,
   parameter int STACK_DEPTH = 16,
   parameter int ADDR_WIDTH  = $clog2(STACK_DEPTH)
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem_q [STACK_DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem_q[waddr] <= wdata;
   end

   assign rdata = mem_q[raddr];

endmodule

// File: rtl/stack_lifo.sv
// LIFO stack with a registered read port, a one-cycle data_valid pulse and sticky error flags.
// The top word lives at mem[count-1]; a push targets mem[count].
module stack_lifo
   import stack_pkg::*;
#(
   parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
   parameter int STACK_DEPTH = DEF_STACK_DEPTH,
   parameter int ADDR_WIDTH  = $clog2(STACK_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  peek,
   input  logic [DATA_WIDTH-1:0] data_in,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  full,
   output logic                  empty,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  overflow,
   output logic                  underflow
);

   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(STACK_DEPTH);

   logic [ADDR_WIDTH:0]   count_q, count_d, count_m1;
   logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
   logic                  data_valid_q, data_valid_d;
   logic                  overflow_q, overflow_d;
   logic                  underflow_q, underflow_d;
   logic [2:0]            op;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_waddr, top_addr;
   logic [DATA_WIDTH-1:0] ram_rdata;

   assign full     = (count_q == DEPTH_C);
   assign empty    = (count_q == '0);
   assign count_m1 = count_q - 1'b1;
   assign top_addr = count_m1[ADDR_WIDTH-1:0];

   stack_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .STACK_DEPTH(STACK_DEPTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(data_in),
      .raddr(top_addr),
      .rdata(ram_rdata)
   );

   always_comb begin
      op           = decode_op(push, pop, peek, empty, full);
      count_d      = count_q;
      data_out_d   = data_out_q;
      data_valid_d = 1'b0;
      overflow_d   = overflow_q;
      underflow_d  = underflow_q;
      ram_we       = 1'b0;
      ram_waddr    = count_q[ADDR_WIDTH-1:0];

      case (op)
         PUSH: begin
            ram_we  = 1'b1;
            count_d = count_q + 1'b1;
         end
         POP: begin
            data_out_d   = ram_rdata;
            data_valid_d = 1'b1;
            count_d      = count_m1;
         end
         PEEK: begin
            data_out_d   = ram_rdata;
            data_valid_d = 1'b1;
         end
         REPLACE: begin
            data_out_d   = ram_rdata;
            data_valid_d = 1'b1;
            ram_we       = 1'b1;
            ram_waddr    = top_addr;
         end
         BYPASS: begin
            data_out_d   = data_in;
            data_valid_d = 1'b1;
         end
         default: ;
      endcase

      // A peek alongside an accepted push still returns the old top.
      if (peek && !pop && !empty) begin
         data_out_d   = ram_rdata;
         data_valid_d = 1'b1;
      end

      if (push && !pop && full)            overflow_d  = 1'b1;
      if ((pop || peek) && empty && !push) underflow_d = 1'b1;

      // Reset cycles must not disturb memory.
      if (!rst_n) ram_we = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q      <= '0;
         data_out_q   <= '0;
         data_valid_q <= 1'b0;
         overflow_q   <= 1'b0;
         underflow_q  <= 1'b0;
      end else begin
         count_q      <= count_d;
         data_out_q   <= data_out_d;
         data_valid_q <= data_valid_d;
         overflow_q   <= overflow_d;
         underflow_q  <= underflow_d;
      end
   end

   assign count      = count_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign overflow   = overflow_q;
   assign underflow  = underflow_q;

endmodule
